slurm32_cpu_memory_stage: RTL and testbench

Memory-access pipeline stage directly downstream of the execute stage. It accepts one load or store request per memory instruction, runs a valid/ready transaction on the data bus, and stalls the pipeline until the transaction completes. For loads it formats the returned word by byte mask and sign and hands it to writeback. A watchdog aborts hung transactions.

---
 rtl/slurm32_cpu_memory_stage.sv | 200 ++++++++++++++++++++
 tb/tb_slurm32_cpu_memory_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slurm32_cpu_memory_stage.sv
// Memory-access pipeline stage: one valid/ready data-bus transaction per load/store,
// pipeline stall while busy, load result formatting and a watchdog abort.
module slurm32_cpu_memory_stage #(
   parameter int unsigned BITS           = 32,
   parameter int unsigned ADDRESS_BITS   = 32,
   parameter int unsigned REGISTER_BITS  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      CLK,
   input  logic                      RSTb,
   input  logic                      load_memory,
   input  logic                      store_memory,
   input  logic [ADDRESS_BITS-3:0]   load_store_address,
   input  logic [BITS-1:0]           memory_out,
   input  logic [3:0]                memory_mask,
   input  logic                      load_sign,
   input  logic [REGISTER_BITS-1:0]  load_dest,
   output logic                      bus_valid,
   output logic                      bus_wr,
   output logic [ADDRESS_BITS-3:0]   bus_addr,
   output logic [BITS-1:0]           bus_wr_data,
   output logic [3:0]                bus_wr_mask,
   input  logic                      bus_ready,
   input  logic                      bus_rd_valid,
   input  logic [BITS-1:0]           bus_rd_data,
   output logic                      stall,
   output logic                      load_data_valid,
   output logic [BITS-1:0]           load_data,
   output logic [REGISTER_BITS-1:0]  load_data_reg,
   output logic                      bus_error
);

   localparam int unsigned WADDR_BITS = ADDRESS_BITS - 2;
   localparam int unsigned MASK_BITS  = 4;
   localparam int unsigned CNT_BITS   = 8;
   localparam int unsigned BYTE_BITS  = 8;
   localparam int unsigned HALF_BITS  = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT_RD = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_BITS-1:0]       cnt_q, cnt_d;
   logic                      bus_valid_q, bus_valid_d;
   logic                      bus_wr_q, bus_wr_d;
   logic [WADDR_BITS-1:0]     bus_addr_q, bus_addr_d;
   logic [BITS-1:0]           bus_wr_data_q, bus_wr_data_d;
   logic [MASK_BITS-1:0]      bus_wr_mask_q, bus_wr_mask_d;
   logic                      load_sign_q, load_sign_d;
   logic [REGISTER_BITS-1:0]  load_dest_q, load_dest_d;
   logic                      stall_q, stall_d;
   logic                      load_data_valid_q, load_data_valid_d;
   logic [BITS-1:0]           load_data_q, load_data_d;
   logic [REGISTER_BITS-1:0]  load_data_reg_q, load_data_reg_d;
   logic                      bus_error_q, bus_error_d;

   logic capture_c;
   logic handshake_c;
   logic timeout_c;

   assign capture_c   = (load_memory | store_memory) & (memory_mask != '0);
   assign handshake_c = bus_valid_q & bus_ready;
   assign timeout_c   = (cnt_q == CNT_BITS'(TIMEOUT_CYCLES));

   // Select and extend the addressed lanes of a returned word; odd masks pass the word through.
   function automatic logic [BITS-1:0] format_load(input logic [BITS-1:0]      w,
                                                   input logic [MASK_BITS-1:0] m,
                                                   input logic                 s);
      logic [BYTE_BITS-1:0] b;
      logic [HALF_BITS-1:0] h;
      logic [BITS-1:0]      r;
      b = '0;
      h = '0;
      r = w;
      case (m)
         4'b0011: begin h = w[15:0];  r = {{(BITS-HALF_BITS){s & h[15]}}, h}; end
         4'b1100: begin h = w[31:16]; r = {{(BITS-HALF_BITS){s & h[15]}}, h}; end
         4'b0001: begin b = w[7:0];   r = {{(BITS-BYTE_BITS){s & b[7]}}, b}; end
         4'b0010: begin b = w[15:8];  r = {{(BITS-BYTE_BITS){s & b[7]}}, b}; end
         4'b0100: begin b = w[23:16]; r = {{(BITS-BYTE_BITS){s & b[7]}}, b}; end
         4'b1000: begin b = w[31:24]; r = {{(BITS-BYTE_BITS){s & b[7]}}, b}; end
         default: r = w;
      endcase
      return r;
   endfunction

   // State and datapath registers
   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         state_q           <= IDLE;
         cnt_q             <= '0;
         bus_valid_q       <= 1'b0;
         bus_wr_q          <= 1'b0;
         bus_addr_q        <= '0;
         bus_wr_data_q     <= '0;
         bus_wr_mask_q     <= '0;
         load_sign_q       <= 1'b0;
         load_dest_q       <= '0;
         stall_q           <= 1'b0;
         load_data_valid_q <= 1'b0;
         load_data_q       <= '0;
         load_data_reg_q   <= '0;
         bus_error_q       <= 1'b0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         bus_valid_q       <= bus_valid_d;
         bus_wr_q          <= bus_wr_d;
         bus_addr_q        <= bus_addr_d;
         bus_wr_data_q     <= bus_wr_data_d;
         bus_wr_mask_q     <= bus_wr_mask_d;
         load_sign_q       <= load_sign_d;
         load_dest_q       <= load_dest_d;
         stall_q           <= stall_d;
         load_data_valid_q <= load_data_valid_d;
         load_data_q       <= load_data_d;
         load_data_reg_q   <= load_data_reg_d;
         bus_error_q       <= bus_error_d;
      end
   end

   // Next-state logic; completion is checked before the watchdog so it wins a tie
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (capture_c) state_d = REQ;
         end
         REQ: begin
            if (handshake_c)    state_d = bus_wr_q ? IDLE : WAIT_RD;
            else if (timeout_c) state_d = IDLE;
         end
         WAIT_RD: begin
            if (bus_rd_valid)   state_d = IDLE;
            else if (timeout_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      cnt_d             = '0;
      bus_wr_d          = bus_wr_q;
      bus_addr_d        = bus_addr_q;
      bus_wr_data_d     = bus_wr_data_q;
      bus_wr_mask_d     = bus_wr_mask_q;
      load_sign_d       = load_sign_q;
      load_dest_d       = load_dest_q;
      load_data_valid_d = 1'b0;
      load_data_d       = load_data_q;
      load_data_reg_d   = load_data_reg_q;
      bus_error_d       = 1'b0;
      bus_valid_d       = (state_d == REQ);
      stall_d           = (state_d != IDLE);

      if (state_d == state_q && state_q != IDLE) cnt_d = cnt_q + CNT_BITS'(1);

      case (state_q)
         IDLE: begin
            if (capture_c) begin
               bus_wr_d      = ~load_memory;
               bus_addr_d    = load_store_address;
               bus_wr_data_d = memory_out;
               bus_wr_mask_d = memory_mask;
               load_sign_d   = load_sign;
               load_dest_d   = load_dest;
            end
         end
         REQ: begin
            if (!handshake_c && timeout_c) bus_error_d = 1'b1;
         end
         WAIT_RD: begin
            if (bus_rd_valid) begin
               load_data_d       = format_load(bus_rd_data, bus_wr_mask_q, load_sign_q);
               load_data_valid_d = 1'b1;
               load_data_reg_d   = load_dest_q;
            end else if (timeout_c) begin
               bus_error_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus_valid       = bus_valid_q;
   assign bus_wr          = bus_wr_q;
   assign bus_addr        = bus_addr_q;
   assign bus_wr_data     = bus_wr_data_q;
   assign bus_wr_mask     = bus_wr_mask_q;
   assign stall           = stall_q;
   assign load_data_valid = load_data_valid_q;
   assign load_data       = load_data_q;
   assign load_data_reg   = load_data_reg_q;
   assign bus_error       = bus_error_q;

endmodule

// File: tb/tb_slurm32_cpu_memory_stage.sv
// Bench for slurm32_cpu_memory_stage: table of load/store vectors with a bus/load
// scoreboard, plus hand sequences for masked-off requests, watchdog and reset.
module tb_slurm32_cpu_memory_stage;

   logic        CLK;
   logic        RSTb;
   logic        load_memory, store_memory;
   logic [29:0] load_store_address;
   logic [31:0] memory_out;
   logic [3:0]  memory_mask;
   logic        load_sign;
   logic [3:0]  load_dest;
   logic        bus_valid, bus_wr;
   logic [29:0] bus_addr;
   logic [31:0] bus_wr_data;
   logic [3:0]  bus_wr_mask;
   logic        bus_ready, bus_rd_valid;
   logic [31:0] bus_rd_data;
   logic        stall, load_data_valid;
   logic [31:0] load_data;
   logic [3:0]  load_data_reg;
   logic        bus_error;

   slurm32_cpu_memory_stage dut (
      .CLK(CLK), .RSTb(RSTb),
      .load_memory(load_memory), .store_memory(store_memory),
      .load_store_address(load_store_address), .memory_out(memory_out),
      .memory_mask(memory_mask), .load_sign(load_sign), .load_dest(load_dest),
      .bus_valid(bus_valid), .bus_wr(bus_wr), .bus_addr(bus_addr),
      .bus_wr_data(bus_wr_data), .bus_wr_mask(bus_wr_mask),
      .bus_ready(bus_ready), .bus_rd_valid(bus_rd_valid), .bus_rd_data(bus_rd_data),
      .stall(stall), .load_data_valid(load_data_valid), .load_data(load_data),
      .load_data_reg(load_data_reg), .bus_error(bus_error)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        wr;
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } bus_exp_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  dst;
   } ld_exp_t;

   // op: 0 store, 1 load, 2 load and store together
   typedef struct {
      int          op;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic        sign;
      logic [3:0]  dest;
      logic [31:0] rdata;
      int          rdy_dly;
      int          rd_dly;
      logic [31:0] exp_data;
   } vec_t;

   bus_exp_t bus_q[$];
   ld_exp_t  ld_q[$];
   bus_exp_t mon_b;
   ld_exp_t  mon_l;
   vec_t     vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bus_valid"}, 32'(bus_valid), 32'd0);
      chk({tag, "_bus_wr"}, 32'(bus_wr), 32'd0);
      chk({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
      chk({tag, "_bus_wr_data"}, bus_wr_data, 32'd0);
      chk({tag, "_bus_wr_mask"}, 32'(bus_wr_mask), 32'd0);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_ld_valid"}, 32'(load_data_valid), 32'd0);
      chk({tag, "_load_data"}, load_data, 32'd0);
      chk({tag, "_load_data_reg"}, 32'(load_data_reg), 32'd0);
      chk({tag, "_bus_error"}, 32'(bus_error), 32'd0);
   endtask

   // Scoreboard: bus handshakes and load writebacks are matched against queued expectations
   always @(negedge CLK) begin
      if (RSTb && bus_valid && bus_ready) begin
         if (bus_q.size() == 0) chk("bus_unexpected_handshake", 32'd1, 32'd0);
         else begin
            mon_b = bus_q.pop_front();
            chk("sb_bus_wr", 32'(bus_wr), 32'(mon_b.wr));
            chk("sb_bus_addr", 32'(bus_addr), 32'(mon_b.addr));
            chk("sb_bus_mask", 32'(bus_wr_mask), 32'(mon_b.mask));
            if (mon_b.wr) chk("sb_bus_wr_data", bus_wr_data, mon_b.data);
         end
      end
      if (load_data_valid) begin
         if (ld_q.size() == 0) chk("ld_unexpected_valid", 32'd1, 32'd0);
         else begin
            mon_l = ld_q.pop_front();
            chk("sb_load_data", load_data, mon_l.data);
            chk("sb_load_data_reg", 32'(load_data_reg), 32'(mon_l.dst));
         end
      end
   end

   task automatic drive_req(input vec_t v);
      bus_exp_t be;
      ld_exp_t  le;
      load_memory        = (v.op != 0);
      store_memory       = (v.op != 1);
      load_store_address = v.addr;
      memory_out         = v.wdata;
      memory_mask        = v.mask;
      load_sign          = v.sign;
      load_dest          = v.dest;
      be.wr   = (v.op == 0);
      be.addr = v.addr;
      be.data = v.wdata;
      be.mask = v.mask;
      bus_q.push_back(be);
      if (v.op != 0) begin
         le.data = v.exp_data;
         le.dst  = v.dest;
         ld_q.push_back(le);
      end
   endtask

   task automatic clear_req;
      load_memory  = 1'b0;
      store_memory = 1'b0;
      memory_mask  = 4'h0;
      memory_out   = 32'h0;
   endtask

   // Full transaction for one vector; entered and left just after a clock edge in IDLE
   task automatic run_vec(input vec_t v, input int idx);
      string n;
      n = $sformatf("v%0d", idx);
      drive_req(v);
      tick;
      clear_req();
      chk({n, "_req_valid"}, 32'(bus_valid), 32'd1);
      chk({n, "_req_stall"}, 32'(stall), 32'd1);
      for (int i = 0; i < v.rdy_dly; i++) begin
         tick;
         chk({n, "_hold_valid"}, 32'(bus_valid), 32'd1);
         chk({n, "_hold_addr"}, 32'(bus_addr), 32'(v.addr));
         chk({n, "_hold_stall"}, 32'(stall), 32'd1);
      end
      bus_ready = 1'b1;
      tick;
      bus_ready = 1'b0;
      chk({n, "_acc_valid"}, 32'(bus_valid), 32'd0);
      if (v.op == 0) begin
         chk({n, "_st_stall"}, 32'(stall), 32'd0);
      end else begin
         chk({n, "_ld_stall"}, 32'(stall), 32'd1);
         for (int i = 0; i < v.rd_dly; i++) begin
            tick;
            chk({n, "_wait_stall"}, 32'(stall), 32'd1);
         end
         bus_rd_valid = 1'b1;
         bus_rd_data  = v.rdata;
         tick;
         bus_rd_valid = 1'b0;
         bus_rd_data  = 32'h0;
         chk({n, "_ld_valid"}, 32'(load_data_valid), 32'd1);
         chk({n, "_done_stall"}, 32'(stall), 32'd0);
      end
      tick;
      chk({n, "_ld_valid_off"}, 32'(load_data_valid), 32'd0);
      chk({n, "_idle_stall"}, 32'(stall), 32'd0);
   endtask

   // Watchdog: with_ready=1 aborts in WAIT_RD, otherwise in REQ
   task automatic timeout_seq(input logic with_ready, input string n);
      vec_t v;
      logic held;
      v = '{1, 30'h55, 32'h0, 4'hF, 1'b0, 4'h9, 32'h0, 0, 0, 32'h0};
      load_memory        = 1'b1;
      load_store_address = v.addr;
      memory_mask        = v.mask;
      load_dest          = v.dest;
      if (with_ready) begin
         bus_exp_t be;
         be.wr = 1'b0; be.addr = v.addr; be.data = 32'h0; be.mask = v.mask;
         bus_q.push_back(be);
      end
      tick;
      clear_req();
      if (with_ready) begin
         bus_ready = 1'b1;
         tick;
         bus_ready = 1'b0;
      end
      // now in cycle 1 of the watched state; the abort edge ends cycle 256
      held = 1'b1;
      for (int i = 1; i < 256; i++) begin
         if (stall !== 1'b1 || bus_error !== 1'b0 || bus_valid !== !with_ready) held = 1'b0;
         tick;
      end
      chk({n, "_held_until_limit"}, 32'(held), 32'd1);
      chk({n, "_no_err_early"}, 32'(bus_error), 32'd0);
      chk({n, "_stall_last"}, 32'(stall), 32'd1);
      tick;
      chk({n, "_bus_error"}, 32'(bus_error), 32'd1);
      chk({n, "_valid_off"}, 32'(bus_valid), 32'd0);
      chk({n, "_stall_off"}, 32'(stall), 32'd0);
      chk({n, "_no_ld_valid"}, 32'(load_data_valid), 32'd0);
      bus_rd_valid = 1'b1;
      bus_rd_data  = 32'h1234_5678;
      tick;
      bus_rd_valid = 1'b0;
      chk({n, "_err_one_cycle"}, 32'(bus_error), 32'd0);
      tick;
      chk({n, "_late_rd_ignored"}, 32'(load_data_valid), 32'd0);
      chk({n, "_late_stall"}, 32'(stall), 32'd0);
   endtask

   initial begin
      vec_t v;
      RSTb               = 1'b0;
      clear_req();
      load_store_address = '0;
      load_sign          = 1'b0;
      load_dest          = '0;
      bus_ready          = 1'b0;
      bus_rd_valid       = 1'b0;
      bus_rd_data        = '0;

      //          op addr          wdata          mask  sign  dest  rdata          rdy rd  expected
      vecs[0]  = '{0, 30'h100,      32'hDEADBEEF, 4'hF, 1'b0, 4'h0, 32'h0,         2, 0, 32'h0};
      vecs[1]  = '{1, 30'h040,      32'h0,        4'h4, 1'b1, 4'h5, 32'h12F03456,  0, 0, 32'hFFFFFFF0};
      vecs[2]  = '{1, 30'h041,      32'h0,        4'hC, 1'b0, 4'h3, 32'h8001ABCD,  0, 0, 32'h00008001};
      vecs[3]  = '{1, 30'h042,      32'h0,        4'h3, 1'b1, 4'h2, 32'h8001ABCD,  1, 1, 32'hFFFFABCD};
      vecs[4]  = '{1, 30'h043,      32'h0,        4'h1, 1'b0, 4'h1, 32'h123456F8,  0, 2, 32'h000000F8};
      vecs[5]  = '{1, 30'h044,      32'h0,        4'h2, 1'b1, 4'h6, 32'h12348000,  0, 0, 32'hFFFFFF80};
      vecs[6]  = '{1, 30'h045,      32'h0,        4'h8, 1'b1, 4'h8, 32'h7F000000,  1, 0, 32'h0000007F};
      vecs[7]  = '{1, 30'h046,      32'h0,        4'h5, 1'b1, 4'hA, 32'hA5A5A5A5,  0, 0, 32'hA5A5A5A5};
      vecs[8]  = '{1, 30'h047,      32'h0,        4'hF, 1'b0, 4'hF, 32'hCAFEF00D,  0, 3, 32'hCAFEF00D};
      vecs[9]  = '{2, 30'h048,      32'h55555555, 4'hF, 1'b0, 4'h4, 32'h11223344,  0, 0, 32'h11223344};
      vecs[10] = '{0, 30'h3FFFFFFF, 32'h0000BEEF, 4'h3, 1'b0, 4'h0, 32'h0,         0, 0, 32'h0};

      repeat (3) tick;
      chk_reset_vals("in_reset");
      RSTb = 1'b1;
      tick;
      chk_reset_vals("after_reset");

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // Zero mask: no bus cycle, no stall
      load_memory = 1'b1;
      memory_mask = 4'h0;
      tick;
      clear_req();
      chk("mask0_valid", 32'(bus_valid), 32'd0);
      chk("mask0_stall", 32'(stall), 32'd0);
      tick;
      chk("mask0_valid2", 32'(bus_valid), 32'd0);

      timeout_seq(1'b0, "to_req");
      timeout_seq(1'b1, "to_wait");

      // Reset while waiting for read data discards the load
      load_memory        = 1'b1;
      load_store_address = 30'h77;
      memory_mask        = 4'hF;
      load_dest          = 4'h7;
      begin
         bus_exp_t be;
         be.wr = 1'b0; be.addr = 30'h77; be.data = 32'h0; be.mask = 4'hF;
         bus_q.push_back(be);
      end
      tick;
      clear_req();
      bus_ready = 1'b1;
      tick;
      bus_ready = 1'b0;
      chk("rst_in_wait_stall", 32'(stall), 32'd1);
      RSTb = 1'b0;
      tick;
      RSTb = 1'b1;
      chk_reset_vals("rst_mid");
      bus_rd_valid = 1'b1;
      bus_rd_data  = 32'hFFFF_FFFF;
      tick;
      bus_rd_valid = 1'b0;
      chk("rst_late_rd_stall", 32'(stall), 32'd0);
      tick;
      chk("rst_late_rd_no_valid", 32'(load_data_valid), 32'd0);

      v = '{1, 30'h78, 32'h0, 4'h1, 1'b1, 4'hB, 32'h0000_0081, 0, 0, 32'hFFFFFF81};
      run_vec(v, 99);

      tick;
      chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
      chk("ld_q_drained", 32'(ld_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
